// File: rtl/flash_controller.sv
// Autonomous ONFI asynchronous-mode NAND self-test: power-up wait, RESET, READ_ID, then DONE.
// Define FLASH_CTRL_PROG_TEST_EN to add an ERASE / PROGRAM / READ-back check of one page.
module flash_controller #(
    parameter int N_BYTES    = 16,
    parameter int PWRUP_CYC  = 100,
    parameter int T_RST_CYC  = 100000,
    parameter int T_BERS_CYC = 500000,
    parameter int T_PROG_CYC = 100000,
    parameter int T_R_CYC    = 10000
) (
    input  logic       CLK_sysClk,
    input  logic       RST_sysRst,
    inout  wire  [7:0] DQ,
    inout  wire        DQS,
    output logic       NAND_CLK,
    output logic       CLE,
    output logic       ALE,
    output logic       WRN,
    output logic       WPN,
    output logic [7:0] CEN,
    output logic [7:0] DEBUG0,
    output logic [7:0] DEBUG1
);

    typedef enum logic [5:0] {
        S_PWRUP    = 6'd0,
        S_RST_CMD  = 6'd1,
        S_WAIT_RST = 6'd2,
        S_ID_CMD   = 6'd3,
        S_ID_ADDR  = 6'd4,
        S_ID_WHR   = 6'd5,
        S_ID_READ  = 6'd6,
        S_ERS_CMD  = 6'd7,
        S_ERS_ADDR = 6'd8,
        S_ERS_CONF = 6'd9,
        S_ERS_WAIT = 6'd10,
        S_PRG_CMD  = 6'd11,
        S_PRG_ADDR = 6'd12,
        S_PRG_DATA = 6'd13,
        S_PRG_CONF = 6'd14,
        S_PRG_WAIT = 6'd15,
        S_RD_CMD   = 6'd16,
        S_RD_ADDR  = 6'd17,
        S_RD_CONF  = 6'd18,
        S_RD_WAIT  = 6'd19,
        S_RD_DATA  = 6'd20,
        S_DONE     = 6'd63
    } state_t;

    localparam logic [7:0]  N_LAST   = 8'(N_BYTES - 1);
    localparam logic [31:0] T_WHR    = 32'd10;

    state_t      state;
    logic [2:0]  ph;
    logic [7:0]  idx;
    logic [31:0] cnt;
    logic [7:0]  id_b [0:4];
    logic        done_r;
    logic        pass_r;
    logic [7:0]  dbg1_r;
`ifdef FLASH_CTRL_PROG_TEST_EN
    logic        err_r;
`endif

    logic        nand_clk_r, cle_r, ale_r, wrn_r, wpn_r, dq_oe_r;
    logic [7:0]  cen_r, dq_out_r;

    // Per-state bus decode: which kind of cycle, what byte, how many items, what follows.
    logic        bus_wr, bus_rd, wr_cle, wr_ale, pass_cond;
    logic [7:0]  wr_byte, n_last;
    logic [31:0] wait_len;
    logic [2:0]  last_ph;
    state_t      succ;

    always_comb begin
        bus_wr   = 1'b0;
        bus_rd   = 1'b0;
        wr_cle   = 1'b0;
        wr_ale   = 1'b0;
        wr_byte  = 8'h00;
        n_last   = 8'd0;
        wait_len = 32'd1;
        succ     = S_DONE;
        case (state)
            S_PWRUP:    begin wait_len = 32'(PWRUP_CYC); succ = S_RST_CMD; end
            S_RST_CMD:  begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'hFF; succ = S_WAIT_RST; end
            S_WAIT_RST: begin wait_len = 32'(T_RST_CYC); succ = S_ID_CMD; end
            S_ID_CMD:   begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h90; succ = S_ID_ADDR; end
            S_ID_ADDR:  begin bus_wr = 1'b1; wr_ale = 1'b1; wr_byte = 8'h00; succ = S_ID_WHR; end
            S_ID_WHR:   begin wait_len = T_WHR; succ = S_ID_READ; end
            S_ID_READ: begin
                bus_rd = 1'b1;
                n_last = 8'd4;
`ifdef FLASH_CTRL_PROG_TEST_EN
                succ = S_ERS_CMD;
`else
                succ = S_DONE;
`endif
            end
            S_ERS_CMD:  begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h60; succ = S_ERS_ADDR; end
            S_ERS_ADDR: begin
                bus_wr = 1'b1; wr_ale = 1'b1; n_last = 8'd2; succ = S_ERS_CONF;
                wr_byte = (idx == 8'd0) ? 8'h01 : 8'h00;
            end
            S_ERS_CONF: begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'hD0; succ = S_ERS_WAIT; end
            S_ERS_WAIT: begin wait_len = 32'(T_BERS_CYC); succ = S_PRG_CMD; end
            S_PRG_CMD:  begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h80; succ = S_PRG_ADDR; end
            S_PRG_ADDR: begin
                bus_wr = 1'b1; wr_ale = 1'b1; n_last = 8'd4; succ = S_PRG_DATA;
                wr_byte = (idx == 8'd2) ? 8'h01 : 8'h00;
            end
            S_PRG_DATA: begin bus_wr = 1'b1; wr_byte = idx ^ 8'hA5; n_last = N_LAST; succ = S_PRG_CONF; end
            S_PRG_CONF: begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h10; succ = S_PRG_WAIT; end
            S_PRG_WAIT: begin wait_len = 32'(T_PROG_CYC); succ = S_RD_CMD; end
            S_RD_CMD:   begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h00; succ = S_RD_ADDR; end
            S_RD_ADDR: begin
                bus_wr = 1'b1; wr_ale = 1'b1; n_last = 8'd4; succ = S_RD_CONF;
                wr_byte = (idx == 8'd2) ? 8'h01 : 8'h00;
            end
            S_RD_CONF:  begin bus_wr = 1'b1; wr_cle = 1'b1; wr_byte = 8'h30; succ = S_RD_WAIT; end
            S_RD_WAIT:  begin wait_len = 32'(T_R_CYC); succ = S_RD_DATA; end
            S_RD_DATA:  begin bus_rd = 1'b1; n_last = N_LAST; succ = S_DONE; end
            default: ;
        endcase
        last_ph = bus_wr ? 3'd4 : 3'd3;
`ifdef FLASH_CTRL_PROG_TEST_EN
        pass_cond = ~err_r;
`else
        pass_cond = (id_b[0] != 8'h00) && (id_b[0] != 8'hFF);
`endif
    end

    // Pin registers are loaded from the decode of the current state/phase, so every
    // pin lags the FSM by exactly one cycle; DQ is therefore sampled when ph == 2,
    // which is the edge closing the second WRN-low cycle on the pins.
    always_ff @(posedge CLK_sysClk) begin
        if (RST_sysRst) begin
            state      <= S_PWRUP;
            ph         <= 3'd0;
            idx        <= 8'd0;
            cnt        <= 32'd0;
            for (int i = 0; i < 5; i++) id_b[i] <= 8'h00;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            dbg1_r     <= 8'h00;
`ifdef FLASH_CTRL_PROG_TEST_EN
            err_r      <= 1'b0;
`endif
            nand_clk_r <= 1'b1;
            cle_r      <= 1'b0;
            ale_r      <= 1'b0;
            wrn_r      <= 1'b1;
            wpn_r      <= 1'b0;
            cen_r      <= 8'hFF;
            dq_oe_r    <= 1'b0;
            dq_out_r   <= 8'h00;
        end else begin
            wpn_r      <= 1'b1;
            cen_r      <= (state == S_PWRUP || state == S_DONE) ? 8'hFF : 8'hFE;
            cle_r      <= bus_wr & wr_cle;
            ale_r      <= bus_wr & wr_ale;
            nand_clk_r <= ~(bus_wr && (ph == 3'd1 || ph == 3'd2));
            wrn_r      <= ~(bus_rd && ph <= 3'd1);
            dq_oe_r    <= bus_wr;
            dq_out_r   <= bus_wr ? wr_byte : 8'h00;

            if (bus_wr || bus_rd) begin
                if (bus_rd && ph == 3'd2) begin
                    if (state == S_ID_READ) begin
                        id_b[idx[2:0]] <= DQ;
                    end
`ifdef FLASH_CTRL_PROG_TEST_EN
                    else if (DQ != (idx ^ 8'hA5)) begin
                        err_r <= 1'b1;
                    end
`endif
                end
                if (ph == last_ph) begin
                    ph <= 3'd0;
                    if (idx == n_last) begin
                        idx   <= 8'd0;
                        state <= succ;
                        if (state == S_ID_READ) dbg1_r <= id_b[0];
                        if (succ == S_DONE) begin
                            done_r <= 1'b1;
                            pass_r <= pass_cond;
                        end
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end else begin
                    ph <= ph + 3'd1;
                end
            end else if (state != S_DONE) begin
                if (cnt + 32'd1 >= wait_len) begin
                    cnt   <= 32'd0;
                    state <= succ;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

    assign DQ       = dq_oe_r ? dq_out_r : 8'hzz;
    assign DQS      = 1'bz;
    assign NAND_CLK = nand_clk_r;
    assign CLE      = cle_r;
    assign ALE      = ale_r;
    assign WRN      = wrn_r;
    assign WPN      = wpn_r;
    assign CEN      = cen_r;
    assign DEBUG0   = {done_r, pass_r, state};
    assign DEBUG1   = dbg1_r;

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller with a small behavioural NAND responder on DQ.
// Covers the default build; FLASH_CTRL_PROG_TEST_EN adds the page program/read-back steps.
module tb_flash_controller;

    localparam int N_BYTES    = 4;
    localparam int PWRUP_CYC  = 10;
    localparam int T_RST_CYC  = 20;
    localparam int T_BERS_CYC = 30;
    localparam int T_PROG_CYC = 25;
    localparam int T_R_CYC    = 15;

    logic       clk;
    logic       rst;
    tri1  [7:0] dq;
    tri1        dqs;
    logic       nand_clk, cle, ale, wrn, wpn;
    logic [7:0] cen, debug0, debug1;

    int checks   = 0;
    int failures = 0;

    flash_controller #(
        .N_BYTES(N_BYTES), .PWRUP_CYC(PWRUP_CYC), .T_RST_CYC(T_RST_CYC),
        .T_BERS_CYC(T_BERS_CYC), .T_PROG_CYC(T_PROG_CYC), .T_R_CYC(T_R_CYC)
    ) dut (
        .CLK_sysClk(clk), .RST_sysRst(rst), .DQ(dq), .DQS(dqs),
        .NAND_CLK(nand_clk), .CLE(cle), .ALE(ale), .WRN(wrn), .WPN(wpn),
        .CEN(cen), .DEBUG0(debug0), .DEBUG1(debug1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NAND responder: latches on WE# rising, drives DQ while RE# is low.
    logic [7:0] id_mem [0:4];
    logic [7:0] page [0:255];
    logic [7:0] last_cmd;
    logic [7:0] model_byte;
    logic       corrupt;
    int         rd_ptr, prog_ptr, id_strobes, rd_count, we_count;
    logic [7:0] cmd_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] prog_q[$];
    logic [7:0] exp_q[$];

    always_comb begin
        if (last_cmd == 8'h90)
            model_byte = (rd_ptr < 5) ? id_mem[rd_ptr[2:0]] : 8'h00;
        else
            model_byte = page[rd_ptr[7:0]] ^ ((corrupt && rd_ptr == 2) ? 8'h01 : 8'h00);
    end

    assign dq = (wrn == 1'b0) ? model_byte : 8'hzz;

    always @(posedge nand_clk) begin
        if (cen[0] == 1'b0) begin
            we_count++;
            if (cle) begin
                last_cmd = dq;
                cmd_q.push_back(dq);
                rd_ptr = 0;
                if (dq == 8'h80) prog_ptr = 0;
                if (dq == 8'hD0) for (int i = 0; i < 256; i++) page[i] = 8'hFF;
            end else if (ale) begin
                addr_q.push_back(dq);
            end else begin
                prog_q.push_back(dq);
                page[prog_ptr[7:0]] = dq;
                prog_ptr++;
            end
        end
    end

    always @(posedge wrn) begin
        if (cen[0] == 1'b0) begin
            rd_count++;
            if (last_cmd == 8'h90) id_strobes++;
            rd_ptr++;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        cmd_q.delete();
        addr_q.delete();
        prog_q.delete();
        last_cmd   = 8'h00;
        rd_ptr     = 0;
        prog_ptr   = 0;
        id_strobes = 0;
        rd_count   = 0;
        we_count   = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (5) tick();
        clear_model();
    endtask

    task automatic wait_done(input string tag);
        int   n;
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 5000) begin
            tick();
            n++;
            if (debug0[5:0] == 6'd63) hit = 1'b1;
        end
        chk(tag, {31'd0, hit}, 32'd1);
        repeat (2) tick();
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_cen"},      {24'd0, cen},    32'hFF);
        chk({tag, "_nand_clk"}, {31'd0, nand_clk}, 32'd1);
        chk({tag, "_wrn"},      {31'd0, wrn},    32'd1);
        chk({tag, "_wpn"},      {31'd0, wpn},    32'd0);
        chk({tag, "_cle_ale"},  {30'd0, cle, ale}, 32'd0);
        chk({tag, "_dq_hiz"},   {24'd0, dq},     32'hFF);
        chk({tag, "_dqs_hiz"},  {31'd0, dqs},    32'd1);
        chk({tag, "_debug0"},   {24'd0, debug0}, 32'h00);
    endtask

    initial begin
        int n, low, we_snap, rd_snap;
        logic [7:0] dbg_snap;

        id_mem = '{8'h2C, 8'h68, 8'h04, 8'h46, 8'h89};
        for (int i = 0; i < 256; i++) page[i] = 8'hFF;
        corrupt = 1'b0;
        rst = 1'b1;
        clear_model();

        // Reset values
        apply_reset();
        check_reset_pins("reset");
        chk("reset_debug1", {24'd0, debug1}, 32'h00);

        // First command: RESET 0xFF after the power-up idle period
        rst = 1'b0;
        n = 0;
        while (cle !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("pwrup_cycles", n, PWRUP_CYC + 1);
        chk("rst_cmd_dq", {24'd0, dq}, 32'hFF);
        chk("rst_cmd_cen", {24'd0, cen}, 32'hFE);
        chk("rst_cmd_setup_we", {31'd0, nand_clk}, 32'd1);
        chk("debug1_before_id", {24'd0, debug1}, 32'h00);
        low = 0;
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (nand_clk == 1'b0) low++;
            else if (low > 0) break;
        end
        chk("we_low_cycles", low, 2);
        chk("hold_dq", {24'd0, dq}, 32'hFF);
        chk("hold_cle", {31'd0, cle}, 32'd1);

        // READ_ID and DONE
        wait_done("done_timeout_1");
        chk("cmd0", {24'd0, (cmd_q.size() > 0) ? cmd_q[0] : 8'h00}, 32'hFF);
        chk("cmd1", {24'd0, (cmd_q.size() > 1) ? cmd_q[1] : 8'h00}, 32'h90);
        chk("id_addr", {24'd0, (addr_q.size() > 0) ? addr_q[0] : 8'hEE}, 32'h00);
        chk("id_strobes", id_strobes, 5);
        chk("debug1_id0", {24'd0, debug1}, 32'h2C);
        chk("done_cen", {24'd0, cen}, 32'hFF);
        chk("done_dq_hiz", {24'd0, dq}, 32'hFF);
        chk("done_pins", {29'd0, nand_clk, wrn, wpn}, 32'h7);
`ifdef FLASH_CTRL_PROG_TEST_EN
        chk("addr_bytes", addr_q.size(), 14);
        chk("cmd_count", cmd_q.size(), 8);
        chk("rd_count", rd_count, 5 + N_BYTES);
        exp_q = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
        chk("prog_count", prog_q.size(), N_BYTES);
        for (int i = 0; i < N_BYTES; i++)
            chk($sformatf("prog_byte%0d", i), {24'd0, (prog_q.size() > i) ? prog_q[i] : 8'h00}, {24'd0, exp_q[i]});
`else
        chk("addr_bytes", addr_q.size(), 1);
        chk("rd_count", rd_count, 5);
`endif
        chk("done_debug0_pass", {24'd0, debug0}, 32'hFF);

        // DONE holds: no further bus cycles, status stable
        we_snap = we_count;
        rd_snap = rd_count;
        dbg_snap = debug0;
        repeat (30) tick();
        chk("idle_we", we_count, we_snap);
        chk("idle_rd", rd_count, rd_snap);
        chk("idle_debug0", {24'd0, debug0}, {24'd0, dbg_snap});

        // Reset in the middle of a bus cycle, then restart with a bad ID byte 0
        id_mem[0] = 8'hFF;
        apply_reset();
        rst = 1'b0;
        n = 0;
`ifdef FLASH_CTRL_PROG_TEST_EN
        while (prog_q.size() < 2 && n < 5000) begin
`else
        while (id_strobes < 2 && n < 5000) begin
`endif
            tick();
            n++;
        end
        chk("midop_reached", {31'd0, n < 5000}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_reset_pins("midop");
        clear_model();
        repeat (4) tick();
        rst = 1'b0;
        wait_done("done_timeout_2");
        chk("restart_cmd0", {24'd0, (cmd_q.size() > 0) ? cmd_q[0] : 8'h00}, 32'hFF);
        chk("debug1_bad_id", {24'd0, debug1}, 32'hFF);
`ifdef FLASH_CTRL_PROG_TEST_EN
        chk("restart_debug0", {24'd0, debug0}, 32'hFF);
        corrupt = 1'b1;
        apply_reset();
        rst = 1'b0;
        wait_done("done_timeout_3");
        chk("corrupt_debug0", {24'd0, debug0}, 32'hBF);
`else
        chk("bad_id_debug0", {24'd0, debug0}, 32'hBF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_controller.md
FLASH_CONTROLLER -- requirements
Module: flash_controller

Interface
REQ-001 SHALL have parameter N_BYTES, default 16: page bytes programmed and read back (1..255).
REQ-002 SHALL have parameter PWRUP_CYC, default 100: idle cycles after reset before the first command.
REQ-003 SHALL have parameter T_RST_CYC, default 100000: fixed wait after the RESET command.
REQ-004 SHALL have parameters T_BERS_CYC, T_PROG_CYC and T_R_CYC, defaults 500000, 100000 and 10000: fixed waits after erase, program and read confirms.
REQ-005 SHALL have ports in this order: CLK_sysClk in 1, system clock (100 MHz); RST_sysRst in 1, synchronous active-high reset.
REQ-006 SHALL have port DQ inout 8: NAND data/command/address bus.
REQ-007 SHALL have port DQS inout 1: NAND strobe, never driven, always high-Z.
REQ-008 SHALL have ports NAND_CLK out 1 (WE#, active low), CLE out 1 and ALE out 1.
REQ-009 SHALL have ports WRN out 1 (RE#, active low) and WPN out 1 (write-protect, active low).
REQ-010 SHALL have port CEN out 8: chip enables, active low; only CEN[0] is ever asserted.
REQ-011 SHALL have ports DEBUG0 out 8 and DEBUG1 out 8: status.
REQ-012 SHALL be a single clock domain: one clock, synchronous active-high reset.

Function
REQ-013 SHALL run an autonomous ONFI asynchronous-mode self-test after reset, with no host interface.
REQ-014 SHALL use this sequence: PWRUP, RESET (0xFF), WAIT_RST, READ_ID (0x90, addr 0x00, read 5 bytes), optional ERASE/PROG/READ, then DONE.
REQ-015 SHALL execute a write bus cycle as follows:
- 1 setup cycle: CLE/ALE/DQ valid, NAND_CLK=1;
- 2 cycles with NAND_CLK=0;
- 2 hold cycles with NAND_CLK=1, DQ still driven.
REQ-016 SHALL, on a command cycle, assert CLE=1 and ALE=0; on an address cycle, CLE=0 and ALE=1; on a data-in cycle, both 0.
REQ-017 SHALL execute a read bus cycle as WRN=0 for 2 cycles, sampling DQ on the last low cycle, then WRN=1 for 2 cycles, with DQ high-Z.
REQ-018 SHALL wait 10 cycles (tWHR) between the last address cycle and the first read cycle.
REQ-019 SHALL drive DQ only during write cycles and keep it high-Z otherwise.
REQ-020 SHALL hold CEN[0]=0 from the RESET command until DONE; CEN=0xFF in DONE.
REQ-021 SHALL keep WPN=1 outside reset.
REQ-022 SHALL store the 5 ID bytes; DEBUG1 = ID byte 0 once READ_ID completes, 0x00 before then.
REQ-023 SHALL use DEBUG0 = {done, pass, state[5:0]}, where the state code is the current FSM state index (PWRUP=0, DONE=63).
REQ-024 SHALL, without the test, set pass=1 at DONE iff ID byte 0 is neither 0x00 nor 0xFF.
REQ-025 SHALL time all waits with free-running counters; the block has no ready/busy input.
REQ-026 SHALL, in DONE, remain idle, hold all outputs stable and issue no further cycles.

Reset
REQ-027 SHALL, on reset, drive CEN=0xFF, CLE=0, ALE=0, NAND_CLK=1, WRN=1, WPN=0, DQ high-Z, DQS high-Z, DEBUG0=0x00 and DEBUG1=0x00.
REQ-028 SHALL clear the FSM, counters, ID registers and pass/error flags on reset.
REQ-029 SHALL, on reset mid-operation (including mid bus cycle), apply the reset values on the next edge and restart from PWRUP.

Configuration
REQ-030 SHALL, with FLASH_CTRL_PROG_TEST_EN defined, run ERASE/PROG/READ after READ_ID:
- ERASE: 0x60, row 0x01,0x00,0x00, 0xD0, wait T_BERS_CYC;
- PROG: 0x80, addr 0x00,0x00,0x01,0x00,0x00, N_BYTES data, 0x10, wait T_PROG_CYC;
- READ: 0x00, same 5 addr, 0x30, wait T_R_CYC, read N_BYTES.
REQ-031 SHALL use program data byte i = i[7:0] XOR 0xA5.
REQ-032 SHALL, with FLASH_CTRL_PROG_TEST_EN defined, compare each read-back byte and set pass=1 at DONE iff all N_BYTES match.
REQ-033 SHALL, without FLASH_CTRL_PROG_TEST_EN, go directly from READ_ID to DONE and use the REQ-024 pass rule.

Verification
REQ-034 SHALL verify reset: RST_sysRst=1 for 5 cycles -> CEN=0xFF, NAND_CLK=1, WRN=1, WPN=0, DQ and DQS high-Z, DEBUG0=0x00.
REQ-035 SHALL verify command timing: release reset -> after PWRUP_CYC, DQ=0xFF with CLE=1, NAND_CLK low exactly 2 cycles, CEN[0]=0.
REQ-036 SHALL verify READ_ID: model ID 0x2C,0x68,0x04,0x46,0x89 -> DEBUG1=0x2C and 5 read strobes occur after 0x90/0x00.
REQ-037 SHALL verify the macro-off DONE state: macro off, ID byte 0 0x2C -> DEBUG0=0xFF (done=1, pass=1, state=63); with ID byte 0 0xFF, pass=0.
REQ-038 SHALL verify the macro-on data path with N_BYTES=4:
- bytes 0xA5,0xA4,0xA7,0xA6 are programmed and read back;
- result pass=1;
- a corrupted model byte gives pass=0.
REQ-039 SHALL verify reset mid-PROG-data: assert reset -> outputs return to reset values next cycle and the sequence restarts with RESET 0xFF.
